// File: rtl/buzzer_scheduler_if.sv
// Request/status bundle between the clock-alarm control (master) and buzzer_scheduler (slave).
interface buzzer_scheduler_if;
  localparam int unsigned NSRC = 3;
  localparam int unsigned HP_W = 16;

  logic [NSRC-1:0] Req;
  logic            Mute;
  logic            Tone_En;
  logic [HP_W-1:0] Half_Period;
  logic [NSRC-1:0] Grant;
  logic            Busy;
  logic            Done;

  modport master (output Req, Mute, input Tone_En, Half_Period, Grant, Busy, Done);
  modport slave  (input Req, Mute, output Tone_En, Half_Period, Grant, Busy, Done);
endinterface

// File: rtl/buzzer_scheduler.sv
// Fixed-priority buzzer sharing for alarm/chime/key-click with timed ON/OFF beep sequencing.
// Optional feature macro BUZZER_PREEMPT_EN: a pending alarm aborts a chime or key-click pattern.
module buzzer_scheduler #(
  parameter int unsigned TICK_DIV     = 50_000,
  parameter int unsigned ALARM_HP     = 25_000,
  parameter int unsigned ALARM_BEEPS  = 4,
  parameter int unsigned ALARM_ON_MS  = 100,
  parameter int unsigned ALARM_OFF_MS = 100,
  parameter int unsigned CHIME_HP     = 50_000,
  parameter int unsigned CHIME_BEEPS  = 1,
  parameter int unsigned CHIME_ON_MS  = 500,
  parameter int unsigned CHIME_OFF_MS = 200,
  parameter int unsigned KEY_HP       = 12_500,
  parameter int unsigned KEY_BEEPS    = 1,
  parameter int unsigned KEY_ON_MS    = 30,
  parameter int unsigned KEY_OFF_MS   = 20
) (
  input logic               CLK,
  input logic               RST,
  buzzer_scheduler_if.slave bus
);
  localparam int unsigned NSRC = 3;
  localparam int unsigned SRC_W = 2;
  localparam int unsigned PH_W = 10;
  localparam int unsigned BP_W = 4;
  localparam int unsigned HP_W = 16;
  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'((TICK_DIV > 0) ? TICK_DIV - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_e;

  // Zero-valued timing parameters behave as 1.
  function automatic logic [PH_W-1:0] nz_ph(input int unsigned v);
    return (v == 0) ? PH_W'(1) : PH_W'(v);
  endfunction

  function automatic logic [PH_W-1:0] on_ms(input logic [SRC_W-1:0] src);
    case (src)
      2'd0:    on_ms = nz_ph(ALARM_ON_MS);
      2'd1:    on_ms = nz_ph(CHIME_ON_MS);
      default: on_ms = nz_ph(KEY_ON_MS);
    endcase
  endfunction

  function automatic logic [PH_W-1:0] off_ms(input logic [SRC_W-1:0] src);
    case (src)
      2'd0:    off_ms = nz_ph(ALARM_OFF_MS);
      2'd1:    off_ms = nz_ph(CHIME_OFF_MS);
      default: off_ms = nz_ph(KEY_OFF_MS);
    endcase
  endfunction

  function automatic logic [BP_W-1:0] beeps(input logic [SRC_W-1:0] src);
    int unsigned b;
    case (src)
      2'd0:    b = ALARM_BEEPS;
      2'd1:    b = CHIME_BEEPS;
      default: b = KEY_BEEPS;
    endcase
    return (b == 0) ? BP_W'(1) : BP_W'(b);
  endfunction

  function automatic logic [HP_W-1:0] half_per(input logic [SRC_W-1:0] src);
    case (src)
      2'd0:    half_per = HP_W'(ALARM_HP);
      2'd1:    half_per = HP_W'(CHIME_HP);
      default: half_per = HP_W'(KEY_HP);
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BP_W-1:0]   beep_q, beep_d;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic              done_evt_q, done_evt_d;
  logic              tone_en_q, tone_en_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [NSRC-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick_c;
  logic              expire_c;
  logic [NSRC-1:0]   sel_c;

  assign tick_c   = (presc_q == PS_LAST);
  assign expire_c = tick_c && (phase_q <= PH_W'(1));
  assign sel_c    = pend_q & (~pend_q + NSRC'(1));

  // Sequencer: grant, ON/OFF phase timing, beep count and pending bookkeeping.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    pend_d     = pend_q;
    phase_d    = phase_q;
    beep_d     = beep_q;
    presc_d    = tick_c ? '0 : presc_q + PS_W'(1);
    done_evt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (pend_q != '0) begin
          case (sel_c)
            3'b001:  src_d = 2'd0;
            3'b010:  src_d = 2'd1;
            default: src_d = 2'd2;
          endcase
          pend_d  = pend_q & ~sel_c;
          beep_d  = beeps(src_d);
          phase_d = on_ms(src_d);
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (expire_c) begin
          phase_d = off_ms(src_q);
          state_d = ST_OFF;
        end else if (tick_c) begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_OFF: begin
        if (expire_c) begin
          if (beep_q <= BP_W'(1)) begin
            beep_d     = '0;
            done_evt_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            beep_d  = beep_q - BP_W'(1);
            phase_d = on_ms(src_q);
            state_d = ST_ON;
          end
        end else if (tick_c) begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef BUZZER_PREEMPT_EN
    if ((state_q != ST_IDLE) && (src_q != 2'd0) && pend_q[0]) begin
      state_d    = ST_IDLE;
      done_evt_d = 1'b0;
    end
`endif
    pend_d = pend_d | bus.Req;
  end

  // Outputs trail the state by one cycle, so every output edge sees identical phase lengths.
  always_comb begin
    tone_en_d = (state_q == ST_ON) && !bus.Mute;
    busy_d    = (state_q != ST_IDLE);
    grant_d   = busy_d ? (NSRC'(1) << src_q) : '0;
    hp_d      = (state_q == ST_ON) ? half_per(src_q) : hp_q;
    done_d    = done_evt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      pend_q     <= '0;
      phase_q    <= '0;
      beep_q     <= '0;
      presc_q    <= '0;
      done_evt_q <= 1'b0;
      tone_en_q  <= 1'b0;
      hp_q       <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      pend_q     <= pend_d;
      phase_q    <= phase_d;
      beep_q     <= beep_d;
      presc_q    <= presc_d;
      done_evt_q <= done_evt_d;
      tone_en_q  <= tone_en_d;
      hp_q       <= hp_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.Tone_En     = tone_en_q;
  assign bus.Half_Period = hp_q;
  assign bus.Grant       = grant_q;
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
endmodule

// File: tb/tb_buzzer_scheduler.sv
// Scoreboard bench for buzzer_scheduler with a short tick (TICK_DIV=4); honours BUZZER_PREEMPT_EN.
module tb_buzzer_scheduler;
  localparam int unsigned TD = 4;

  typedef struct {
    logic [2:0]  grant;
    logic [15:0] hp;
    int          on_len;
    int          gap;
  } burst_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buzzer_scheduler_if bus ();
  buzzer_scheduler #(.TICK_DIV(TD)) dut (.CLK(clk), .RST(rst), .bus(bus));

  burst_t exp_q[$];
  int     done_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     rise_cyc = 0;
  int     fall_cyc = 0;
  int     done_cnt = 0;
  logic   prev_tone = 1'b0;
  logic   prev_done = 1'b0;
  logic   mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic burst_t mk(input logic [2:0] g, input logic [15:0] hp, input int on_len,
                                input int gap);
    burst_t b;
    b.grant = g; b.hp = hp; b.on_len = on_len; b.gap = gap;
    return b;
  endfunction

  // Tone bursts and Done pulses observed at the falling edge are matched against the queues.
  always @(negedge clk) begin
    burst_t b;
    int g;
    cyc++;
    if (mon_en && !rst) begin
      if (bus.Tone_En && !prev_tone) begin
        rise_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_burst", 32'(exp_q.size()), 1);
        else begin
          check("burst_grant", 32'(bus.Grant), 32'(exp_q[0].grant));
          check("burst_half_period", 32'(bus.Half_Period), 32'(exp_q[0].hp));
          if (exp_q[0].gap > 0) check("burst_gap", 32'(cyc - fall_cyc), 32'(exp_q[0].gap));
        end
      end
      if (!bus.Tone_En && prev_tone) begin
        fall_cyc = cyc;
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("burst_on_len", 32'(cyc - rise_cyc), 32'(b.on_len));
        end
      end
      if (bus.Done) begin
        done_cnt++;
        check("done_with_busy_low", 32'(bus.Busy), 0);
        check("done_width", 32'(prev_done), 0);
        if (done_q.size() == 0) check("unexpected_done", 32'(done_q.size()), 1);
        else begin
          g = done_q.pop_front();
          if (g >= 0) check("done_off_len", 32'(cyc - fall_cyc), 32'(g));
        end
      end
    end
    prev_tone = bus.Tone_En;
    prev_done = bus.Done;
  end

  task automatic pulse_req(input logic [2:0] r);
    bus.Req = r;
    @(negedge clk);
    bus.Req = 3'b000;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      quiet = bus.Busy ? 0 : quiet + 1;
    end
    if (quiet < 4) check("idle_timeout", 32'(quiet), 4);
    check("bursts_left", 32'(exp_q.size()), 0);
    check("dones_left", 32'(done_q.size()), 0);
  endtask

  task automatic wait_tone(input int budget, output int lat);
    lat = 0;
    while (!bus.Tone_En && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.Tone_En) check("tone_timeout", 32'(bus.Tone_En), 1);
  endtask

  initial begin
    int lat;
    int d0;
    int busy_cnt;
    int bad_grant;
    int tone_cnt;
    rst = 1'b1;
    bus.Req = 3'b000;
    bus.Mute = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tone_en", 32'(bus.Tone_En), 0);
    check("rst_busy", 32'(bus.Busy), 0);
    check("rst_grant", 32'(bus.Grant), 0);
    check("rst_done", 32'(bus.Done), 0);
    check("rst_half_period", 32'(bus.Half_Period), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single key click: 2-cycle latency, 120 on / 80 off.
    exp_q.push_back(mk(3'b100, 16'd12500, 30 * TD, 0));
    done_q.push_back(20 * TD);
    pulse_req(3'b100);
    wait_tone(20, lat);
    check("req_to_tone", 32'(lat), 2);
    check("key_half_period", 32'(bus.Half_Period), 12500);
    check("key_busy", 32'(bus.Busy), 1);
    wait_idle(2000);

    // Alarm: four 400/400 bursts.
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3'b001, 16'd25000, 100 * TD, (i == 0) ? 0 : 100 * TD));
    done_q.push_back(100 * TD);
    pulse_req(3'b001);
    wait_idle(5000);

    // Simultaneous requests: alarm, chime, key with one idle cycle between patterns.
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3'b001, 16'd25000, 100 * TD, (i == 0) ? 0 : 100 * TD));
    exp_q.push_back(mk(3'b010, 16'd50000, 500 * TD, 100 * TD + 1));
    exp_q.push_back(mk(3'b100, 16'd12500, 30 * TD, 200 * TD + 1));
    done_q.push_back(100 * TD);
    done_q.push_back(200 * TD);
    done_q.push_back(20 * TD);
    d0 = done_cnt;
    pulse_req(3'b111);
    wait_idle(12000);
    check("simultaneous_dones", 32'(done_cnt - d0), 3);

    // Alarm arriving 50 cycles into a chime ON phase.
`ifdef BUZZER_PREEMPT_EN
    exp_q.push_back(mk(3'b010, 16'd50000, 53, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3'b001, 16'd25000, 100 * TD, (i == 0) ? 1 : 100 * TD));
    done_q.push_back(100 * TD);
`else
    exp_q.push_back(mk(3'b010, 16'd50000, 500 * TD, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3'b001, 16'd25000, 100 * TD, (i == 0) ? 200 * TD + 1 : 100 * TD));
    done_q.push_back(200 * TD);
    done_q.push_back(100 * TD);
`endif
    d0 = done_cnt;
    pulse_req(3'b010);
    wait_tone(20, lat);
    repeat (50) @(negedge clk);
    pulse_req(3'b001);
    wait_idle(12000);
`ifdef BUZZER_PREEMPT_EN
    check("preempt_dones", 32'(done_cnt - d0), 1);
`else
    check("preempt_dones", 32'(done_cnt - d0), 2);
`endif

    // Muted alarm: no tone, Busy/Grant timing unchanged.
    bus.Mute = 1'b1;
    done_q.push_back(-1);
    busy_cnt = 0; bad_grant = 0; tone_cnt = 0;
    pulse_req(3'b001);
    repeat (3300) begin
      @(negedge clk);
      if (bus.Busy) busy_cnt++;
      if (bus.Busy && bus.Grant != 3'b001) bad_grant++;
      if (bus.Tone_En) tone_cnt++;
    end
    bus.Mute = 1'b0;
    check("mute_busy_cycles", 32'(busy_cnt), 800 * TD);
    check("mute_grant_errs", 32'(bad_grant), 0);
    check("mute_tone_cycles", 32'(tone_cnt), 0);
    wait_idle(100);

    // Reset mid-ON with a key click still pending.
    mon_en = 1'b0;
    pulse_req(3'b001);
    repeat (10) @(negedge clk);
    pulse_req(3'b100);
    repeat (5) @(negedge clk);
    check("pre_rst_tone", 32'(bus.Tone_En), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tone_en", 32'(bus.Tone_En), 0);
    check("mid_rst_busy", 32'(bus.Busy), 0);
    check("mid_rst_grant", 32'(bus.Grant), 0);
    check("mid_rst_half_period", 32'(bus.Half_Period), 0);
    rst = 1'b0;
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.Busy) busy_cnt++;
    end
    check("pending_cleared_by_rst", 32'(busy_cnt), 0);
    mon_en = 1'b1;

    // Repeated key requests during a click queue exactly one more click.
    exp_q.push_back(mk(3'b100, 16'd12500, 30 * TD, 0));
    exp_q.push_back(mk(3'b100, 16'd12500, 30 * TD, 20 * TD + 1));
    done_q.push_back(20 * TD);
    done_q.push_back(20 * TD);
    d0 = done_cnt;
    pulse_req(3'b100);
    wait_tone(20, lat);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_req(3'b100);
      repeat (3) @(negedge clk);
    end
    wait_idle(2000);
    check("repeat_dones", 32'(done_cnt - d0), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/buzzer_scheduler.md
# buzzer_scheduler

Fixed-priority scheduler that shares the single buzzer tone generator between three requesters: alarm (0), hourly chime (1) and key-click (2). It latches request pulses, grants one source at a time and sequences that source's beep pattern as timed ON/OFF phases. It drives the tone generator's half-period value and enable. It sits between the clock/alarm control logic and the buzzer tone generator.

## Interface
- TICK_DIV, 50_000: CLK cycles per 1 ms phase tick (50 MHz).
- ALARM_HP / ALARM_BEEPS / ALARM_ON_MS / ALARM_OFF_MS, 25_000 / 4 / 100 / 100: source 0 pattern.
- CHIME_HP / CHIME_BEEPS / CHIME_ON_MS / CHIME_OFF_MS, 50_000 / 1 / 500 / 200: source 1 pattern.
- KEY_HP / KEY_BEEPS / KEY_ON_MS / KEY_OFF_MS, 12_500 / 1 / 30 / 20: source 2 pattern.
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- Req  in  3  request pulses; bit i = source i; level is tolerated and re-arms each cycle.
- Mute  in  1  forces Tone_En low; sequencing continues unchanged.
- Tone_En  out  1  tone generator enable; reset 0.
- Half_Period  out  16  tone half-period in CLK cycles; reset 0; holds last value when idle.
- Grant  out  3  one-hot active source during ON/OFF; reset 0.
- Busy  out  1  state != IDLE; reset 0.
- Done  out  1  one-cycle pulse on normal pattern completion; reset 0.

## Operation
- Pending[2:0]: Req[i] high sets Pending[i]. It is cleared on the cycle source i is granted. A Req for the granted source on its grant cycle leaves Pending set, queuing exactly one repeat; requests do not count.
- States: IDLE, ON, OFF.
- IDLE: if any Pending, grant the lowest index. Load Half_Period, beep counter = BEEPS and phase counter = ON_MS. Go to ON.
- ON: Tone_En = ~Mute. When the phase expires, load OFF_MS and go to OFF.
- OFF: Tone_En = 0. When the phase expires, decrement the beep counter. If it is nonzero, go to ON. Otherwise pulse Done, clear Grant and go to IDLE.
- Phase timing: the prescaler restarts on every state entry. Each ms count is exactly TICK_DIV cycles, so ON lasts ON_MS*TICK_DIV cycles exactly.
- Zero values: a parameter value of 0 for ON_MS or OFF_MS is treated as 1. BEEPS=0 is treated as 1.
- Counter widths: phase counter 10 bits, beep counter 4 bits, prescaler sized by $clog2(TICK_DIV).
- Simultaneous requests: lowest index wins. The others stay pending and are served in order from successive IDLE visits.
- Reset mid-operation: all state, Pending and outputs go to reset values on the next edge; the tone stops immediately.

## Timing
- Req sampled high at edge t: Pending is set at t. IDLE grants at edge t+1. Busy, Grant and Tone_En are high from edge t+1 + 1 = t+2, i.e. 2 cycles from Req to tone.
- Between back-to-back patterns there is exactly one IDLE cycle.
- Done is high for the one cycle following the last OFF expiry, coincident with the entry to IDLE.
- Half_Period is valid on the same edge that Tone_En first rises.

## Configuration
- BUZZER_PREEMPT_EN defined:
  - While serving source 1 or 2 (ON or OFF), Pending[0] set aborts the pattern at the next edge and the state goes to IDLE.
  - The aborted request is discarded and no Done pulse is issued.
  - The alarm is granted on the following edge.
- BUZZER_PREEMPT_EN undefined: patterns are never interrupted, and the alarm waits for the current pattern to finish.

## Test plan
- **Single key click** (TICK_DIV=4): Req=3'b100 for 1 cycle.
  - Tone_En rises 2 cycles later with Half_Period=12_500.
  - Tone_En stays high 120 cycles, then is low 80 cycles.
  - Done pulses once; Busy falls with Done.
- **Alarm pattern**: Req[0] pulse gives 4 ON bursts of 400 cycles, separated by 400-cycle OFF phases, with Half_Period=25_000 and Grant=3'b001 throughout.
- **Simultaneous requests**: Req=3'b111 on one cycle.
  - Served in order alarm, chime, key, each separated by one IDLE cycle.
  - 3 Done pulses total.
- **Preemption**:
  - With BUZZER_PREEMPT_EN, Req[0] arrives 50 cycles into a chime ON phase. Chime aborts with no Done, and alarm ON starts 2 cycles later.
  - Without the macro, alarm ON starts 1 cycle after the chime Done.
- **Mute and reset**: during an alarm, Mute=1 holds Tone_En at 0 while Grant/Busy timing is unchanged. RST asserted mid-ON clears all outputs and Pending on the next edge.
- **Repeat queuing**: Req[2] asserted 3 times during an active key click gives exactly one additional click.
